// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: sole driver of the 4-bit HD44780 bus. Runs the power-on
// init list, then round-robin shares the bus between two byte requesters,
// one whole transaction at a time. Each byte goes out as two timed nibbles.
module lcd_bus_arbiter #(
    parameter int EN_HIGH_CYC   = 800,
    parameter int EN_LOW_CYC    = 800,
    parameter int LONG_CYC      = 60000,
    parameter int INIT_WAIT_CYC = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rq0_valid,
    input  logic       rq0_rs,
    input  logic [7:0] rq0_data,
    input  logic       rq0_last,
    output logic       rq0_ready,
    input  logic       rq1_valid,
    input  logic       rq1_rs,
    input  logic [7:0] rq1_data,
    input  logic       rq1_last,
    output logic       rq1_ready,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [3:0] lcd_data,
    output logic       init_done,
    output logic       busy,
    output logic [1:0] grant
);

    localparam int MAX_A   = (EN_HIGH_CYC > EN_LOW_CYC) ? EN_HIGH_CYC : EN_LOW_CYC;
    localparam int MAX_B   = (LONG_CYC > INIT_WAIT_CYC) ? LONG_CYC : INIT_WAIT_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] T_HI   = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] T_LO   = CW'(EN_LOW_CYC - 1);
    localparam logic [CW-1:0] T_LONG = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] T_INIT = CW'(INIT_WAIT_CYC - 1);

    typedef enum logic [3:0] {
        INIT_WAIT, NIB_EN, NIB_GAP, ARB, HI_EN, HI_GAP, LO_EN, LO_GAP, LONG_WAIT
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    init_idx_reg, init_idx_next;
    logic          init_done_reg, init_done_next;
    logic [7:0]    byte_reg, byte_next;
    logic          rs_reg, rs_next;
    logic          last_reg, last_next;
    logic          lock_reg, lock_next;
    logic          owner_reg, owner_next;
    logic          rr_reg, rr_next;
    logic [1:0]    grant_reg, grant_next;
    logic          lcd_en_reg, lcd_en_next;
    logic          lcd_rs_reg, lcd_rs_next;
    logic [3:0]    lcd_data_reg, lcd_data_next;

    logic [1:0]    valid;
    logic [1:0]    ready_vec;
    logic          sel_idx, sel_ok, arb_open, accept;
    logic          sel_rs, sel_last;
    logic [7:0]    sel_data;
    logic          byte_done, start_req, start_rs;
    logic [7:0]    start_byte;

    // Init list: indices 0..3 are lone nibbles, 4..7 are full command bytes.
    function automatic logic [3:0] init_nibble(input logic [2:0] idx);
        return (idx == 3'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd4:    return 8'h28;
            3'd5:    return 8'h0C;
            3'd6:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    assign valid    = {rq1_valid, rq0_valid};
    assign arb_open = (state_reg == ARB) && init_done_reg;
    assign sel_data = sel_idx ? rq1_data : rq0_data;
    assign sel_rs   = sel_idx ? rq1_rs   : rq0_rs;
    assign sel_last = sel_idx ? rq1_last : rq0_last;
    assign accept   = arb_open && sel_ok && valid[sel_idx];

    // Pick the requester: the lock owner sticks; otherwise alternate away from rr.
    always_comb begin
        sel_idx = 1'b0;
        sel_ok  = 1'b0;
        if (lock_reg) begin
            sel_idx = owner_reg;
            sel_ok  = 1'b1;
        end else if (valid == 2'b11) begin
            sel_idx = ~rr_reg;
            sel_ok  = 1'b1;
        end else if (valid[0]) begin
            sel_idx = 1'b0;
            sel_ok  = 1'b1;
        end else if (valid[1]) begin
            sel_idx = 1'b1;
            sel_ok  = 1'b1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_vec[gi] = arb_open && sel_ok && (sel_idx == 1'(gi));
    end

    assign rq0_ready = ready_vec[0];
    assign rq1_ready = ready_vec[1];

    // Next-state and next-output logic; bus pins only move when en rises.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        init_idx_next  = init_idx_reg;
        init_done_next = init_done_reg;
        byte_next      = byte_reg;
        rs_next        = rs_reg;
        last_next      = last_reg;
        lock_next      = lock_reg;
        owner_next     = owner_reg;
        rr_next        = rr_reg;
        grant_next     = grant_reg;
        lcd_en_next    = lcd_en_reg;
        lcd_rs_next    = lcd_rs_reg;
        lcd_data_next  = lcd_data_reg;
        byte_done      = 1'b0;
        start_req      = 1'b0;
        start_byte     = 8'h00;
        start_rs       = 1'b0;

        case (state_reg)
            INIT_WAIT: if (cnt_reg == T_INIT) begin
                state_next    = NIB_EN;
                cnt_next      = '0;
                init_idx_next = 3'd0;
                lcd_en_next   = 1'b1;
                lcd_rs_next   = 1'b0;
                lcd_data_next = init_nibble(3'd0);
            end
            NIB_EN: if (cnt_reg == T_HI) begin
                state_next  = NIB_GAP;
                cnt_next    = '0;
                lcd_en_next = 1'b0;
            end
            NIB_GAP: if (cnt_reg == T_LO) begin
                if (init_idx_reg == 3'd3) begin
                    init_idx_next = 3'd4;
                    start_req     = 1'b1;
                    start_byte    = init_byte(3'd4);
                end else begin
                    state_next    = NIB_EN;
                    cnt_next      = '0;
                    init_idx_next = init_idx_reg + 3'd1;
                    lcd_en_next   = 1'b1;
                    lcd_data_next = init_nibble(init_idx_reg + 3'd1);
                end
            end
            ARB: begin
                cnt_next = '0;
                if (accept) begin
                    start_req  = 1'b1;
                    start_byte = sel_data;
                    start_rs   = sel_rs;
                    last_next  = sel_last;
                    grant_next = sel_idx ? 2'b10 : 2'b01;
                    owner_next = sel_idx;
                    lock_next  = ~sel_last;
                    if (sel_last) rr_next = sel_idx;
                end
            end
            HI_EN: if (cnt_reg == T_HI) begin
                state_next  = HI_GAP;
                cnt_next    = '0;
                lcd_en_next = 1'b0;
            end
            HI_GAP: if (cnt_reg == T_LO) begin
                state_next    = LO_EN;
                cnt_next      = '0;
                lcd_en_next   = 1'b1;
                lcd_data_next = byte_reg[3:0];
            end
            LO_EN: if (cnt_reg == T_HI) begin
                state_next  = LO_GAP;
                cnt_next    = '0;
                lcd_en_next = 1'b0;
            end
            LO_GAP: if (cnt_reg == T_LO) begin
                cnt_next = '0;
                if (!rs_reg && (byte_reg == 8'h01 || byte_reg == 8'h02))
                    state_next = LONG_WAIT;
                else
                    byte_done = 1'b1;
            end
            LONG_WAIT: if (cnt_reg == T_LONG) begin
                cnt_next  = '0;
                byte_done = 1'b1;
            end
            default: begin
                state_next = INIT_WAIT;
                cnt_next   = '0;
            end
        endcase

        // A finished byte either advances the init list or returns to arbitration.
        if (byte_done) begin
            if (!init_done_reg) begin
                if (init_idx_reg == 3'd7) begin
                    state_next     = ARB;
                    init_done_next = 1'b1;
                end else begin
                    init_idx_next = init_idx_reg + 3'd1;
                    start_req     = 1'b1;
                    start_byte    = init_byte(init_idx_reg + 3'd1);
                end
            end else begin
                state_next = ARB;
                if (last_reg) grant_next = 2'b00;
            end
        end

        if (start_req) begin
            state_next    = HI_EN;
            cnt_next      = '0;
            byte_next     = start_byte;
            rs_next       = start_rs;
            lcd_en_next   = 1'b1;
            lcd_rs_next   = start_rs;
            lcd_data_next = start_byte[7:4];
        end
    end

    // State, counters and bus pins; reset aborts any strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT_WAIT;
            cnt_reg       <= '0;
            init_idx_reg  <= 3'd0;
            init_done_reg <= 1'b0;
            byte_reg      <= 8'h00;
            rs_reg        <= 1'b0;
            last_reg      <= 1'b0;
            lock_reg      <= 1'b0;
            owner_reg     <= 1'b0;
            rr_reg        <= 1'b0;
            grant_reg     <= 2'b00;
            lcd_en_reg    <= 1'b0;
            lcd_rs_reg    <= 1'b0;
            lcd_data_reg  <= 4'h0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            init_idx_reg  <= init_idx_next;
            init_done_reg <= init_done_next;
            byte_reg      <= byte_next;
            rs_reg        <= rs_next;
            last_reg      <= last_next;
            lock_reg      <= lock_next;
            owner_reg     <= owner_next;
            rr_reg        <= rr_next;
            grant_reg     <= grant_next;
            lcd_en_reg    <= lcd_en_next;
            lcd_rs_reg    <= lcd_rs_next;
            lcd_data_reg  <= lcd_data_next;
        end
    end

    assign lcd_en    = lcd_en_reg;
    assign lcd_rs    = lcd_rs_reg;
    assign lcd_data  = lcd_data_reg;
    assign init_done = init_done_reg;
    assign busy      = (state_reg != ARB);
    assign grant     = grant_reg;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed vectors for the LCD bus arbiter with small
// timing parameters; expected nibbles and cycle counts are hand-derived.
module tb_lcd_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rq0_valid = 1'b0, rq0_rs = 1'b0, rq0_last = 1'b0;
    logic [7:0] rq0_data = 8'h00;
    logic       rq1_valid = 1'b0, rq1_rs = 1'b0, rq1_last = 1'b0;
    logic [7:0] rq1_data = 8'h00;
    logic       rq0_ready, rq1_ready;
    logic       lcd_rs, lcd_en, init_done, busy;
    logic [3:0] lcd_data;
    logic [1:0] grant;

    lcd_bus_arbiter #(
        .EN_HIGH_CYC(4), .EN_LOW_CYC(2), .LONG_CYC(20), .INIT_WAIT_CYC(10)
    ) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_rs(rq0_rs), .rq0_data(rq0_data),
        .rq0_last(rq0_last), .rq0_ready(rq0_ready),
        .rq1_valid(rq1_valid), .rq1_rs(rq1_rs), .rq1_data(rq1_data),
        .rq1_last(rq1_last), .rq1_ready(rq1_ready),
        .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_data(lcd_data),
        .init_done(init_done), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    int asrt_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;
    int viol = 0;
    int last_rise = 0;
    int rise_cyc[$], rise_dat[$], rise_rs[$], hi_len[$];
    logic prev_en = 1'b0, prev_rs = 1'b0;
    logic [3:0] prev_dat = 4'h0;
    int exp_nib[12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 6, 0, 1};

    task automatic check(input string tag, input int got, input int exp);
        asrt_cnt++;
        if (got != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor: logs every en rise, en-high length, and any pin change
    // that does not coincide with an en rise.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (lcd_en && !prev_en) begin
                rise_cyc.push_back(cyc);
                rise_dat.push_back(int'(lcd_data));
                rise_rs.push_back(int'(lcd_rs));
                last_rise = cyc;
            end else if (lcd_data != prev_dat || lcd_rs != prev_rs) begin
                viol++;
            end
            if (!lcd_en && prev_en) hi_len.push_back(cyc - last_rise);
        end
        prev_en  = lcd_en;
        prev_dat = lcd_data;
        prev_rs  = lcd_rs;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        rise_cyc.delete();
        rise_dat.delete();
        rise_rs.delete();
        hi_len.delete();
    endtask

    task automatic init_check(input string tag, input int exp_rdy);
        int t0, done_at, early;
        t0 = cyc;
        done_at = -1;
        early = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (init_done) begin
                done_at = cyc - t0;
                break;
            end
            if (rq0_ready || rq1_ready) early++;
        end
        check({tag, "_done_cyc"}, done_at, 102);
        check({tag, "_early_ready"}, early, 0);
        check({tag, "_ready_at_done"}, int'(rq0_ready), exp_rdy);
        check({tag, "_nib_count"}, rise_dat.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < rise_dat.size()) begin
                check($sformatf("%s_nib%0d_data", tag, i), rise_dat[i], exp_nib[i]);
                check($sformatf("%s_nib%0d_cyc", tag, i), rise_cyc[i] - t0, 10 + 6 * i);
                check($sformatf("%s_nib%0d_rs", tag, i), rise_rs[i], 0);
            end
        end
    endtask

    task automatic send(input bit idx, input bit rs, input logic [7:0] d,
                        input bit last, output int acc);
        acc = -1;
        if (idx) begin
            rq1_rs = rs; rq1_data = d; rq1_last = last; rq1_valid = 1'b1;
        end else begin
            rq0_rs = rs; rq0_data = d; rq0_last = last; rq0_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            #1;
            if (idx ? rq1_ready : rq0_ready) begin
                acc = cyc;
                break;
            end
            step();
        end
        step();
        if (idx) rq1_valid = 1'b0;
        else     rq0_valid = 1'b0;
        if (acc < 0) check("send_timeout", acc, 0);
    endtask

    task automatic wait_idle(input int acc, output int dt);
        dt = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!busy) begin
                dt = cyc - acc;
                break;
            end
        end
    endtask

    int acc, acc0, acc1, dt, c1, p0, p1, rdy_seen, busy_seen, idle;
    bit gpend;
    int gseq[$];
    logic [7:0] b0[2] = '{8'h30, 8'h31};
    logic [7:0] b1[2] = '{8'h52, 8'h53};
    int exp_t3[8] = '{5, 2, 5, 3, 3, 0, 3, 1};
    int exp_g3[4] = '{2, 2, 1, 1};

    initial begin
        // Reset state
        step();
        step();
        check("rst_lcd_en", int'(lcd_en), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_data", int'(lcd_data), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 1);

        // Power-on init sequence
        clear_log();
        rst = 1'b0;
        init_check("init", 0);
        $display("init sequence complete at cycle %0d", cyc);

        // Single byte 0x41 from rq0
        clear_log();
        send(1'b0, 1'b1, 8'h41, 1'b1, acc);
        check("t2_ready_pulse", int'(rq0_ready), 0);
        check("t2_grant", int'(grant), 1);
        wait_idle(acc, dt);
        check("t2_arb_latency", dt, 13);
        check("t2_grant_clear", int'(grant), 0);
        check("t2_rises", rise_dat.size(), 2);
        if (rise_dat.size() == 2 && hi_len.size() == 2) begin
            check("t2_hi_data", rise_dat[0], 4);
            check("t2_lo_data", rise_dat[1], 1);
            check("t2_hi_cyc", rise_cyc[0] - acc, 1);
            check("t2_lo_cyc", rise_cyc[1] - acc, 7);
            check("t2_hi_rs", rise_rs[0], 1);
            check("t2_lo_rs", rise_rs[1], 1);
            check("t2_hi_len", hi_len[0], 4);
            check("t2_lo_len", hi_len[1], 4);
        end
        $display("byte 0x41 rq0 accepted at %0d, done after %0d", acc, dt);

        // Both requesters, two-byte transactions each, rr=0
        clear_log();
        p0 = 0; p1 = 0; gpend = 0;
        for (int t = 0; t < 300 && (p0 < 2 || p1 < 2 || gpend); t++) begin
            if (gpend) begin
                gseq.push_back(int'(grant));
                gpend = 0;
            end
            rq0_valid = (p0 < 2); rq0_rs = 1'b1; rq0_last = (p0 == 1);
            rq0_data  = (p0 < 2) ? b0[p0[0]] : 8'h00;
            rq1_valid = (p1 < 2); rq1_rs = 1'b1; rq1_last = (p1 == 1);
            rq1_data  = (p1 < 2) ? b1[p1[0]] : 8'h00;
            #1;
            if (rq0_valid && rq0_ready) begin p0++; gpend = 1; end
            if (rq1_valid && rq1_ready) begin p1++; gpend = 1; end
            step();
        end
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        wait_idle(cyc, dt);
        check("t3_idle_reached", int'(dt >= 0), 1);
        check("t3_grant_count", gseq.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gseq.size()) check($sformatf("t3_grant%0d", i), gseq[i], exp_g3[i]);
        check("t3_rises", rise_dat.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < rise_dat.size()) check($sformatf("t3_nib%0d", i), rise_dat[i], exp_t3[i]);
        check("t3_grant_clear", int'(grant), 0);
        $display("two-requester round complete, %0d grants logged", gseq.size());

        // rq1 locked, then stalls; rq0 must starve
        send(1'b1, 1'b1, 8'h61, 1'b0, acc);
        rq0_rs = 1'b1; rq0_data = 8'h55; rq0_last = 1'b1; rq0_valid = 1'b1;
        rdy_seen = 0; idle = 0; busy_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (rq0_ready) rdy_seen++;
            if (!busy) begin idle = 1; break; end
        end
        check("t4_idle", idle, 1);
        clear_log();
        for (int i = 0; i < 30; i++) begin
            step();
            if (rq0_ready) rdy_seen++;
            if (busy) busy_seen++;
        end
        check("t4_rq0_starved", rdy_seen, 0);
        check("t4_bus_idle", rise_dat.size(), 0);
        check("t4_no_busy", busy_seen, 0);
        check("t4_grant_held", int'(grant), 2);
        c1 = cyc;
        send(1'b1, 1'b1, 8'h62, 1'b1, acc1);
        check("t4_resume_lat", acc1 - c1, 0);
        send(1'b0, 1'b1, 8'h55, 1'b1, acc0);
        check("t4_rq0_after", acc0 - acc1, 13);
        check("t4_rq0_grant", int'(grant), 1);
        wait_idle(acc0, dt);
        check("t4_rq0_done", dt, 13);
        $display("lock stall: rq1 resumed at %0d, rq0 accepted at %0d", acc1, acc0);

        // Clear command 0x01 gets the long hold
        clear_log();
        send(1'b0, 1'b0, 8'h01, 1'b1, acc);
        wait_idle(acc, dt);
        check("t5_long_latency", dt, 33);
        check("t5_rises", rise_dat.size(), 2);
        if (rise_dat.size() == 2) begin
            check("t5_hi_data", rise_dat[0], 0);
            check("t5_lo_data", rise_dat[1], 1);
            check("t5_rs", rise_rs[1], 0);
        end
        $display("clear cmd accepted at %0d, done after %0d", acc, dt);

        // Reset during HI_EN of a byte
        send(1'b0, 1'b1, 8'h48, 1'b1, acc);
        check("t6_en_before", int'(lcd_en), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_en_in_reset", int'(lcd_en), 0);
        check("t6_done_in_reset", int'(init_done), 0);
        check("t6_grant_in_reset", int'(grant), 0);
        check("t6_data_in_reset", int'(lcd_data), 0);
        step();
        rq0_rs = 1'b1; rq0_data = 8'h7A; rq0_last = 1'b1; rq0_valid = 1'b1;
        clear_log();
        rst = 1'b0;
        init_check("reinit", 1);
        step();
        rq0_valid = 1'b0;
        wait_idle(cyc, dt);
        check("t6_final_idle", int'(dt >= 0), 1);
        $display("reset replay complete at cycle %0d", cyc);

        check("bus_pin_stability", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the 4-bit HD44780 character-LCD bus (rs, en, data[7:4]) and is the only block that drives it.
- After reset it runs the LCD power-on init sequence. It then shares the bus between two byte-stream requesters (clock/time writer and message/alarm writer), with round-robin arbitration at transaction granularity.
- Each accepted byte becomes two timed nibble strobes. Clear/home commands get an extra long hold.

Parameters:
EN_HIGH_CYC, 800, cycles lcd_en is held high per nibble
EN_LOW_CYC, 800, cycles lcd_en is held low after each nibble, data/rs held
LONG_CYC, 60000, extra wait after a command byte 0x01 or 0x02 (rs=0)
INIT_WAIT_CYC, 60000, power-up wait before the first init nibble

Ports:
clk  in  1  system clock (Sys_Clk0 domain)
rst  in  1  asynchronous active-high reset
rq0_valid  in  1  requester 0 has a byte
rq0_rs  in  1  0=command, 1=character data
rq0_data  in  8  byte to send
rq0_last  in  1  byte is the final byte of rq0's transaction
rq0_ready  out  1  byte accepted this cycle when rq0_valid=1
rq1_valid, rq1_rs, rq1_data[7:0], rq1_last, rq1_ready: same as rq0, for requester 1
lcd_rs  out  1  LCD register select
lcd_en  out  1  LCD enable strobe
lcd_data  out  4  LCD D7..D4
init_done  out  1  high once the init sequence has completed
busy  out  1  high whenever state != ARB
grant  out  2  one-hot current transaction owner; 00 = none

Behaviour:
- Reset (async, any state): lcd_rs=0, lcd_en=0, lcd_data=0, init_done=0, grant=00, rr pointer=0, lock=0, all counters=0, state=INIT_WAIT.
- Mid-operation reset aborts the current strobe immediately; the init sequence restarts from INIT_WAIT.
- States: INIT_WAIT, NIB_EN, NIB_GAP, ARB, HI_EN, HI_GAP, LO_EN, LO_GAP, LONG_WAIT.
- INIT_WAIT: counts INIT_WAIT_CYC cycles, then starts the init list.
- Init list: single nibbles 3,3,3,2 (rs=0), each sent as NIB_EN then NIB_GAP. Then full command bytes 0x28, 0x0C, 0x06, 0x01, each sent as a normal byte, including the LONG_WAIT after 0x01.
- init_done rises on the first cycle in ARB and stays high until reset.
- rqN_ready: combinational, never high before init_done.
  - Asserted only in ARB, only for the selected requester.
  - Selection when lock=1: only the owner is selected.
  - Selection when lock=0 and both valid: the requester != rr.
  - Selection when lock=0 and one valid: that requester.
- Accept = valid & ready. On accept:
  - rs and data are captured into internal registers.
  - grant is set one-hot to the accepted requester.
  - lock is set to !last.
  - If last: rr is set to the accepted index and grant clears to 00 after the byte completes.
- Byte timing (cycle after accept = cycle 1):
  - HI_EN: lcd_rs=rs, lcd_data=byte[7:4], lcd_en=1 for EN_HIGH_CYC cycles.
  - HI_GAP: lcd_en=0 for EN_LOW_CYC cycles, data and rs held.
  - LO_EN, then LO_GAP: same as HI_EN/HI_GAP with byte[3:0].
  - If rs=0 and byte is 0x01 or 0x02: LONG_WAIT for LONG_CYC cycles.
  - Then ARB.
  - Accept-to-accept minimum spacing: 2*(EN_HIGH_CYC+EN_LOW_CYC)+1 cycles, plus LONG_CYC for clear/home.
- lcd_data and lcd_rs change only in the cycle lcd_en rises. They never change while lcd_en=1 or within the same cycle as its fall.
- Locked owner drops valid mid-transaction: the arbiter waits in ARB with the lock held, and the other requester is starved. This is intended; requesters must finish their transactions.
- valid and ready high in the same cycle as reset deassertion: no accept, because the block is in INIT_WAIT.
- Counters are sized to hold max(INIT_WAIT_CYC, LONG_CYC) and compare against parameter-1. There is no wrap-around within a phase.

Test Plan (use EN_HIGH_CYC=4, EN_LOW_CYC=2, LONG_CYC=20, INIT_WAIT_CYC=10):
- Release reset, no requests:
  - lcd_en first rises at cycle 11 with data=3.
  - Nibble sequence 3,3,3,2,2,8,0,C,0,6,0,1 with rs=0.
  - 20-cycle hold after the final nibble, then init_done=1.
- After init, rq0 sends 0x41, rs=1, last=1:
  - rq0_ready pulses for 1 cycle.
  - en high 4 cycles with data=4, low 2, high 4 with data=1, low 2; rs=1 throughout.
  - Next ARB occurs 13 cycles after accept.
- Both valid, each with a 2-byte transaction, rr=0:
  - rq1 is granted first and both its bytes complete.
  - rq0's bytes follow; grant sequence is 10,10,01,01; no interleaving.
- rq1 locked, rq1_valid dropped for 30 cycles while rq0 is valid: rq0_ready stays 0 and the bus stays idle. rq1 then resumes.
- rq0 sends 0x01, rs=0: a 20-cycle LONG_WAIT follows LO_GAP, and busy=1 throughout.
- Assert rst during HI_EN of a byte: lcd_en=0 in the same cycle, init_done=0, and the full init sequence replays.
